sha_round_sequencer: RTL and testbench

Control and message-schedule block for one SHA-256 compression. It accepts a 512-bit block and a 256-bit chaining state over a valid/ready handshake. It then sequences the external round datapath (working registers a..h plus the new-a/new-e adders) for ROUNDS cycles, supplying K_t and W_t each round. At the end it performs the final chaining add and presents the digest over a second valid/ready handshake.

---
 rtl/sha_round_sequencer.sv | 100 ++++++++++
 tb/tb_sha_round_sequencer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_round_sequencer.sv
// sha_round_sequencer: SHA-256 compression control, message schedule and final chaining add.
// Drives an external a..h round datapath for ROUNDS cycles, then presents the digest.
module sha_round_sequencer #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic [255:0] in_state,
  input  logic         flush,
  output logic         load_state,
  output logic [255:0] state_out,
  output logic         round_en,
  output logic [5:0]   round_idx,
  output logic [31:0]  k_t,
  output logic [31:0]  w_t,
  input  logic [255:0] work_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_digest,
  output logic         busy
);
  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, DONE} state_e;
  localparam logic [5:0] LAST = 6'(ROUNDS - 1);
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
  state_e         state_q;
  logic [31:0]    win_q [16];
  logic [5:0]     t_q;
  logic [255:0]   state_out_q;
  logic [255:0]   digest_q;
  logic [255:0]   digest_d;
  logic [31:0]    w15_d;
  assign w15_d = ssig1(win_q[14]) + win_q[9] + ssig0(win_q[1]) + win_q[0];
  // Word-wise add: carries stop at each 32-bit boundary.
  for (genvar i = 0; i < 8; i++) begin : g_add
    assign digest_d[32*i +: 32] = state_out_q[32*i +: 32] + work_state[32*i +: 32];
  end
  assign in_ready   = state_q == IDLE;
  assign load_state = state_q == LOAD;
  assign round_en   = state_q == ROUND;
  assign out_valid  = state_q == DONE;
  assign busy       = state_q != IDLE;
  assign round_idx  = t_q;
  assign k_t        = round_en ? K[t_q] : '0;
  assign w_t        = round_en ? win_q[0] : '0;
  assign state_out  = state_out_q;
  assign out_digest = digest_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      t_q         <= '0;
      state_out_q <= '0;
      digest_q    <= '0;
      for (int j = 0; j < 16; j++) win_q[j] <= '0;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          for (int j = 0; j < 16; j++) win_q[j] <= in_block[511-32*j -: 32];
          state_out_q <= in_state;
          state_q     <= LOAD;
        end
        LOAD: begin
          t_q     <= '0;
          state_q <= ROUND;
        end
        ROUND: begin
          for (int j = 0; j < 15; j++) win_q[j] <= win_q[j+1];
          win_q[15] <= w15_d;
          t_q       <= t_q == LAST ? t_q : t_q + 6'd1;
          state_q   <= t_q == LAST ? FINAL : ROUND;
        end
        FINAL: begin
          digest_q <= digest_d;
          state_q  <= DONE;
        end
        DONE: if (out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha_round_sequencer.sv
// tb_sha_round_sequencer: directed checks of the SHA-256 round sequencer with a behavioural round datapath.
module tb_sha_round_sequencer;
  logic         clk = 0, rst_n = 0, in_valid = 0, flush = 0, out_ready = 0;
  logic         in_ready, load_state, round_en, out_valid, busy;
  logic [511:0] in_block = '0;
  logic [255:0] in_state = '0, state_out, work_state, out_digest;
  logic [5:0]   round_idx;
  logic [31:0]  k_t, w_t;
  int n_cmp = 0, n_bad = 0;
  bit tie_ready = 0;

  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'b0, 32'h00000018};
  localparam logic [255:0] IV  = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] ABC = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                  32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [255:0] JUNK = {8{32'hdeadbeef}};

  always #5 clk = ~clk;

  sha_round_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_block(in_block), .in_state(in_state), .flush(flush),
    .load_state(load_state), .state_out(state_out), .round_en(round_en),
    .round_idx(round_idx), .k_t(k_t), .w_t(w_t), .work_state(work_state),
    .out_valid(out_valid), .out_ready(out_ready), .out_digest(out_digest), .busy(busy)
  );

  // Behavioural a..h datapath fed by the sequencer's strobes, K and W.
  logic [31:0]  dp [8];
  logic [31:0]  t1, t2;
  logic         ovr_en = 0;
  logic [255:0] ovr = '0;
  assign work_state = ovr_en ? ovr : {dp[0], dp[1], dp[2], dp[3], dp[4], dp[5], dp[6], dp[7]};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  always @(posedge clk) begin
    if (load_state) begin
      for (int i = 0; i < 8; i++) dp[i] <= state_out[255-32*i -: 32];
    end else if (round_en) begin
      t1 = dp[7] + (rotr(dp[4], 6) ^ rotr(dp[4], 11) ^ rotr(dp[4], 25))
         + ((dp[4] & dp[5]) ^ (~dp[4] & dp[6])) + k_t + w_t;
      t2 = (rotr(dp[0], 2) ^ rotr(dp[0], 13) ^ rotr(dp[0], 22))
         + ((dp[0] & dp[1]) ^ (dp[0] & dp[2]) ^ (dp[1] & dp[2]));
      dp[7] <= dp[6]; dp[6] <= dp[5]; dp[5] <= dp[4]; dp[4] <= dp[3] + t1;
      dp[3] <= dp[2]; dp[2] <= dp[1]; dp[1] <= dp[0]; dp[0] <= t1 + t2;
    end
  end

  int load_cnt = 0, round_cnt = 0, run = 0, last_run = 0, overlap = 0, ovalid_cnt = 0;
  logic [31:0] w_seen [64];
  logic [31:0] k_seen [64];
  always @(posedge clk) begin
    if (load_state) load_cnt++;
    if (load_state && round_en) overlap++;
    if (out_valid) ovalid_cnt++;
    if (round_en) begin
      round_cnt++;
      run++;
      w_seen[round_idx] = w_t;
      k_seen[round_idx] = k_t;
    end else if (run != 0) begin
      last_run = run;
      run = 0;
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic accept(input logic [511:0] blk, input logic [255:0] st);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (in_ready) begin
        in_block = blk; in_state = st; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        ok = 1;
      end else @(negedge clk);
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic finish_job(output logic [255:0] dig, output int lat, input bit rel);
    lat = 1;
    while (!out_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    dig = out_digest;
    if (rel) begin
      out_ready = 1;
      @(negedge clk);
      out_ready = tie_ready;
    end
  endtask

  task automatic wait_round(input logic [5:0] t, input string name);
    bit ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (round_en && round_idx == t) ok = 1;
      else @(negedge clk);
    end
    chk(name, ok, 1);
  endtask

  typedef struct {
    logic [255:0] st;
    logic [255:0] ws;
    logic [255:0] exp;
  } vec_t;
  vec_t vt [4];

  initial begin
    logic [255:0] dig, sref;
    int lat, l0, r0, o0, bad_cyc;
    vt[0] = '{st: {32'hffffffff, 32'h12345678, 192'b0}, ws: {32'h00000002, 32'h11111111, 192'b0},
              exp: {32'h00000001, 32'h23456789, 192'b0}};
    vt[1] = '{st: {8{32'hffffffff}}, ws: {8{32'h00000001}}, exp: '0};
    vt[2] = '{st: {8{32'h80000000}}, ws: {8{32'h80000000}}, exp: '0};
    vt[3] = '{st: {32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210,
                   32'h00000000, 32'hffffffff, 32'h7fffffff, 32'h80000001},
              ws: {32'h11111111, 32'h11111111, 32'h11111111, 32'h11111111,
                   32'h11111111, 32'h11111111, 32'h00000001, 32'hffffffff},
              exp: {32'h12345678, 32'h9abcdf00, 32'h0fedcba9, 32'h87654321,
                    32'h11111111, 32'h11111110, 32'h80000000, 32'h80000000}};

    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_strobes", {busy, out_valid, load_state, round_en}, 0);
    chk("rst_datapath_outs", {round_idx, k_t, w_t}, 0);
    chk("rst_digest", out_digest, 0);
    chk("rst_state_out", state_out, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    l0 = load_cnt; r0 = round_cnt;
    accept(ABC_BLK, IV);
    chk("abc_load_state", load_state, 1);
    finish_job(dig, lat, 1);
    chk("abc_latency", lat, 67);
    chk("abc_digest", dig, ABC);
    chk("abc_w16", w_seen[16], 32'h61626380);
    chk("abc_w17", w_seen[17], 32'h000f0000);
    chk("abc_k0", k_seen[0], 32'h428a2f98);
    chk("abc_k63", k_seen[63], 32'hc67178f2);
    chk("abc_loads", load_cnt - l0, 1);
    chk("abc_rounds", round_cnt - r0, 64);
    chk("abc_round_run", last_run, 64);
    chk("abc_back_idle", {in_ready, busy}, 2'b10);

    ovr_en = 1;
    for (int v = 0; v < 4; v++) begin
      ovr = vt[v].ws;
      accept(ABC_BLK, vt[v].st);
      chk($sformatf("vec%0d_state_out", v), state_out, vt[v].st);
      finish_job(dig, lat, 1);
      chk($sformatf("vec%0d_digest", v), dig, vt[v].exp);
    end
    ovr_en = 0;

    accept(ABC_BLK, IV);
    finish_job(dig, lat, 0);
    chk("bp_digest", dig, ABC);
    bad_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_digest !== ABC || in_ready !== 1'b0 || out_valid !== 1'b1) bad_cyc++;
      in_valid = i[0]; in_state = JUNK;
      @(negedge clk);
    end
    in_valid = 0;
    chk("bp_stable_cycles", bad_cyc, 0);
    chk("bp_no_capture", state_out, IV);
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    chk("bp_release_ready", {in_ready, busy, out_valid}, 3'b100);
    in_block = ABC_BLK; in_state = IV; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    chk("bp_next_accept", load_state, 1);

    wait_round(6'd10, "flush_reach_t10");
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush_idle", {busy, round_en, load_state, in_ready}, 4'b0001);
    o0 = ovalid_cnt;
    repeat (80) @(negedge clk);
    chk("flush_no_out_valid", ovalid_cnt - o0, 0);
    sref = state_out;
    in_valid = 1; flush = 1; in_state = JUNK;
    @(negedge clk);
    in_valid = 0; flush = 0;
    chk("flush_priority", {busy, load_state}, 0);
    chk("flush_priority_nocap", state_out, sref);
    accept(ABC_BLK, IV);
    finish_job(dig, lat, 1);
    chk("after_flush_digest", dig, ABC);

    tie_ready = 1; out_ready = 1;
    l0 = load_cnt; r0 = round_cnt;
    accept(ABC_BLK, IV);
    finish_job(dig, lat, 1);
    chk("b2b_digest_a", dig, ABC);
    chk("b2b_run_a", last_run, 64);
    chk("b2b_ready_a", in_ready, 1);
    accept(ABC_BLK, IV);
    finish_job(dig, lat, 1);
    chk("b2b_digest_b", dig, ABC);
    chk("b2b_run_b", last_run, 64);
    chk("b2b_loads", load_cnt - l0, 2);
    chk("b2b_rounds", round_cnt - r0, 128);
    tie_ready = 0; out_ready = 0;

    accept(ABC_BLK, IV);
    wait_round(6'd30, "rst_reach_t30");
    #2 rst_n = 0;
    #1;
    chk("async_rst_strobes", {round_en, out_valid, busy}, 0);
    chk("async_rst_regs", {state_out, k_t}, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("async_rst_ready", {in_ready, busy}, 2'b10);
    o0 = ovalid_cnt;
    repeat (80) @(negedge clk);
    chk("async_rst_no_digest", ovalid_cnt - o0, 0);
    chk("strobe_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
